ram_arbiter: RTL and testbench

- Shares the single-port RAM (load/save/addr/data/value interface) between two bus masters.
  - m0: CPU fetch/data port.
  - m1: loader/DMA or I/O port.
- Sits between the masters and the RAM in the Computer top level.
- Serialises accesses through an IDLE/ACCESS/DONE FSM with round-robin or fixed-priority arbitration.
- Returns read data with a one-cycle done pulse to the winning master.

---
 rtl/ram_arbiter_if.sv | 63 ++++++
 rtl/ram_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles both bus masters and the single-port RAM port that
// ram_arbiter sits between.
//
// Handshake: a master raises mN_req with mN_we/mN_addr/mN_wdata valid and
// holds req until mN_done. The arbiter copies the request on the edge that
// grants it. mN_gnt is high while the master owns the RAM (ACCESS and DONE).
// mN_done is a one-cycle pulse. In a read, mN_rdata is valid from that pulse
// until the master's next read completes. On the RAM side, ram_load/ram_save
// qualify ram_addr/ram_data, and ram_value is sampled RAM_LATENCY cycles
// after the enable first rises.
//
// Modports:
//   slave  - the arbiter's view (requests and ram_value in, everything else out)
//   master - the environment's view (the mirror image)
// dbg_state exposes the arbiter FSM state (IDLE=0, ACCESS=1, DONE=2).
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  m0_req;
  logic                  m0_we;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [DATA_WIDTH-1:0] m0_wdata;
  logic                  m0_gnt;
  logic [DATA_WIDTH-1:0] m0_rdata;
  logic                  m0_done;

  logic                  m1_req;
  logic                  m1_we;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [DATA_WIDTH-1:0] m1_wdata;
  logic                  m1_gnt;
  logic [DATA_WIDTH-1:0] m1_rdata;
  logic                  m1_done;

  logic                  ram_load;
  logic                  ram_save;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data;
  logic [DATA_WIDTH-1:0] ram_value;

  logic [1:0]            dbg_state;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata, m0_done,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata, m1_done,
    output ram_load, ram_save, ram_addr, ram_data,
    input  ram_value,
    output dbg_state
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata, m0_done,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata, m1_done,
    input  ram_load, ram_save, ram_addr, ram_data,
    output ram_value,
    input  dbg_state
  );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port RAM between two bus masters
// (m0 = CPU fetch/data, m1 = loader/DMA or I/O). Accesses are serialised
// through an IDLE -> ACCESS -> DONE FSM. Ties are broken round-robin
// (FIXED_PRIO=0) or always in favour of m0 (FIXED_PRIO=1).
//
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high; aborts any access in flight
//   bus   - ram_arbiter_if.slave: m0_*/m1_* master ports, ram_* RAM port,
//           dbg_state
//
// Timing: a request present in an IDLE cycle is taken at the end of that
// cycle. ACCESS then lasts RAM_LATENCY cycles and DONE lasts one. The done
// pulse therefore appears RAM_LATENCY+1 cycles after the cycle in which the
// request was presented. One access completes every RAM_LATENCY+2 cycles.
module ram_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic          clk,
  input  logic          reset,
  ram_arbiter_if.slave  bus
);

  if (RAM_LATENCY < 1 || RAM_LATENCY > 4) begin : g_bad_latency
    $error("ram_arbiter: RAM_LATENCY must be in 1..4");
  end

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  owner_q;        // 0 = m0, 1 = m1
  logic                  last_winner_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rdata0_q;
  logic [DATA_WIDTH-1:0] rdata1_q;

  logic any_req;
  logic winner;

  // Winner selection. It only matters in IDLE, but it is computed every cycle.
  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    winner  = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_winner_q;
    end else begin
      winner = bus.m1_req;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      owner_q       <= 1'b0;
      last_winner_q <= 1'b1;  // m0 wins the first tie
      we_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            owner_q       <= winner;
            last_winner_q <= winner;
            we_q          <= winner ? bus.m1_we    : bus.m0_we;
            addr_q        <= winner ? bus.m1_addr  : bus.m0_addr;
            data_q        <= winner ? bus.m1_wdata : bus.m0_wdata;
            cnt_q         <= CNT_W'(RAM_LATENCY - 1);
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            // ram_value is valid on this final ACCESS edge.
            if (!we_q) begin
              if (owner_q) rdata1_q <= bus.ram_value;
              else         rdata0_q <= bus.ram_value;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  logic busy;
  logic in_access;
  logic in_done;

  always_comb begin
    busy      = (state_q != IDLE);
    in_access = (state_q == ACCESS);
    in_done   = (state_q == DONE);
  end

  assign bus.m0_gnt    = busy & ~owner_q;
  assign bus.m1_gnt    = busy & owner_q;
  assign bus.m0_done   = in_done & ~owner_q;
  assign bus.m1_done   = in_done & owner_q;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.ram_load  = in_access & ~we_q;
  assign bus.ram_save  = in_access & we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_data  = data_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter. It runs three instances side by side:
//   0: RAM_LATENCY=1, round-robin
//   1: RAM_LATENCY=1, fixed priority
//   2: RAM_LATENCY=3, round-robin
// Each instance has its own RAM model. Expected read data is pushed when a
// request is issued and popped when the matching done pulse appears.
module tb_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst       [3];
  logic        m0_req    [3];
  logic        m0_we     [3];
  logic [31:0] m0_addr   [3];
  logic [31:0] m0_wdata  [3];
  logic        m1_req    [3];
  logic        m1_we     [3];
  logic [31:0] m1_addr   [3];
  logic [31:0] m1_wdata  [3];
  logic        m0_gnt    [3];
  logic        m0_done   [3];
  logic [31:0] m0_rdata  [3];
  logic        m1_gnt    [3];
  logic        m1_done   [3];
  logic [31:0] m1_rdata  [3];
  logic        ram_load  [3];
  logic        ram_save  [3];
  logic [31:0] ram_addr  [3];
  logic [31:0] ram_data  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int FP  = (g == 1) ? 1 : 0;

    ram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    logic [31:0] mem [256];

    initial begin
      for (int a = 0; a < 256; a++) mem[a] = {24'hC0FFEE, a[7:0]};
      mem[8'h10] = 32'hDEADBEEF;
    end

    always @(posedge clk) if (bus.ram_save) mem[bus.ram_addr[7:0]] <= bus.ram_data;

    assign bus.ram_value = bus.ram_load ? mem[bus.ram_addr[7:0]] : 32'hBAD0BAD0;
    assign bus.m0_req    = m0_req[g];
    assign bus.m0_we     = m0_we[g];
    assign bus.m0_addr   = m0_addr[g];
    assign bus.m0_wdata  = m0_wdata[g];
    assign bus.m1_req    = m1_req[g];
    assign bus.m1_we     = m1_we[g];
    assign bus.m1_addr   = m1_addr[g];
    assign bus.m1_wdata  = m1_wdata[g];
    assign m0_gnt[g]     = bus.m0_gnt;
    assign m0_done[g]    = bus.m0_done;
    assign m0_rdata[g]   = bus.m0_rdata;
    assign m1_gnt[g]     = bus.m1_gnt;
    assign m1_done[g]    = bus.m1_done;
    assign m1_rdata[g]   = bus.m1_rdata;
    assign ram_load[g]   = bus.ram_load;
    assign ram_save[g]   = bus.ram_save;
    assign ram_addr[g]   = bus.ram_addr;
    assign ram_data[g]   = bus.ram_data;

    ram_arbiter #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .RAM_LATENCY(LAT),
      .FIXED_PRIO (FP)
    ) u_dut (
      .clk  (clk),
      .reset(rst[g]),
      .bus  (bus.slave)
    );
  end

  // Scoreboard and model state; index idx = 2*instance + master.
  logic [31:0] exp_q [6][$];
  logic [31:0] model_mem [3][256];
  logic [31:0] last_rd [6];
  int          done_cnt [6];
  int          done_cyc [6];
  int          gnt_cyc [6];
  int          load_cyc [3];
  int          save_cyc [3];
  logic [31:0] en_addr [3];
  logic [31:0] en_data [3];
  logic        m1_gnt_seen [3];
  int          ev_m [3][$];
  int          ev_t [3][$];
  logic        mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: invariants, enable/grant bookkeeping and scoreboard pops.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("gnt_exclusive", 32'(m0_gnt[i] & m1_gnt[i]), 32'd0);
        chk("load_save_exclusive", 32'(ram_load[i] & ram_save[i]), 32'd0);
        if (ram_load[i]) begin load_cyc[i]++; en_addr[i] = ram_addr[i]; end
        if (ram_save[i]) begin
          save_cyc[i]++;
          en_addr[i] = ram_addr[i];
          en_data[i] = ram_data[i];
        end
        if (m0_gnt[i]) gnt_cyc[2*i]++;
        if (m1_gnt[i]) begin gnt_cyc[2*i+1]++; m1_gnt_seen[i] = 1'b1; end
        for (int m = 0; m < 2; m++) begin
          int idx;
          logic d;
          logic [31:0] rd;
          idx = 2*i + m;
          d   = (m == 0) ? m0_done[i]  : m1_done[i];
          rd  = (m == 0) ? m0_rdata[i] : m1_rdata[i];
          if (d) begin
            done_cnt[idx]++;
            done_cyc[idx] = cyc;
            ev_m[i].push_back(m);
            ev_t[i].push_back(cyc);
            if (exp_q[idx].size() == 0) chk("unexpected_done", 32'd1, 32'd0);
            else chk("rdata", rd, exp_q[idx].pop_front());
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input int m, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
    if (m == 0) begin
      m0_req[i] = req; m0_we[i] = we; m0_addr[i] = addr; m0_wdata[i] = data;
    end else begin
      m1_req[i] = req; m1_we[i] = we; m1_addr[i] = addr; m1_wdata[i] = data;
    end
  endtask

  // Push the expected rdata for one read of addr by master m of instance i.
  task automatic expect_read(input int i, input int m, input logic [31:0] addr);
    last_rd[2*i+m] = model_mem[i][addr[7:0]];
    exp_q[2*i+m].push_back(last_rd[2*i+m]);
  endtask

  // One complete access. If drop_at > 0, req is withdrawn drop_at cycles after
  // the request was presented.
  task automatic do_access(input int i, input int m, input logic we,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int lat, input int drop_at);
    int idx, b_done, b_own, b_oth, b_ld, b_sv, t0;
    logic got;
    idx = 2*i + m;
    if (we) begin
      model_mem[i][addr[7:0]] = data;
      exp_q[idx].push_back(last_rd[idx]);
    end else begin
      expect_read(i, m, addr);
    end
    b_done = done_cnt[idx]; b_own = gnt_cyc[idx]; b_oth = gnt_cyc[idx ^ 1];
    b_ld = load_cyc[i]; b_sv = save_cyc[i];
    @(posedge clk); #1;
    set_req(i, m, 1'b1, we, addr, data);
    t0 = cyc;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk); #1;
      if (drop_at > 0 && cyc == t0 + drop_at) set_req(i, m, 1'b0, we, addr, data);
      if (done_cnt[idx] != b_done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    set_req(i, m, 1'b0, 1'b0, 32'd0, 32'd0);
    if (got) chk("done_latency", 32'(done_cyc[idx] - t0), 32'(lat + 1));
    @(negedge clk); #1;
    chk("done_once", 32'(done_cnt[idx] - b_done), 32'd1);
    chk("owner_gnt_cycles", 32'(gnt_cyc[idx] - b_own), 32'(lat + 1));
    chk("other_gnt_cycles", 32'(gnt_cyc[idx ^ 1] - b_oth), 32'd0);
    if (we) begin
      chk("save_cycles", 32'(save_cyc[i] - b_sv), 32'(lat));
      chk("load_during_write", 32'(load_cyc[i] - b_ld), 32'd0);
      chk("ram_data", en_data[i], data);
    end else begin
      chk("load_cycles", 32'(load_cyc[i] - b_ld), 32'(lat));
      chk("save_during_read", 32'(save_cyc[i] - b_sv), 32'd0);
    end
    chk("ram_addr", en_addr[i], addr);
  endtask

  task automatic check_quiet(input int i, input string tag);
    chk({tag, "_m0_gnt"}, 32'(m0_gnt[i]), 32'd0);
    chk({tag, "_m1_gnt"}, 32'(m1_gnt[i]), 32'd0);
    chk({tag, "_m0_done"}, 32'(m0_done[i]), 32'd0);
    chk({tag, "_m1_done"}, 32'(m1_done[i]), 32'd0);
    chk({tag, "_load"}, 32'(ram_load[i]), 32'd0);
    chk({tag, "_save"}, 32'(ram_save[i]), 32'd0);
  endtask

  task automatic check_zero_regs(input int i, input string tag);
    chk({tag, "_ram_addr"}, ram_addr[i], 32'd0);
    chk({tag, "_ram_data"}, ram_data[i], 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata[i], 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata[i], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic ok;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      set_req(i, 0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_req(i, 1, 1'b0, 1'b0, 32'd0, 32'd0);
      load_cyc[i] = 0; save_cyc[i] = 0; m1_gnt_seen[i] = 1'b0;
      en_addr[i] = '0; en_data[i] = '0;
      for (int a = 0; a < 256; a++) model_mem[i][a] = {24'hC0FFEE, 8'(a)};
      model_mem[i][8'h10] = 32'hDEADBEEF;
    end
    for (int k = 0; k < 6; k++) begin
      done_cnt[k] = 0; done_cyc[k] = 0; gnt_cyc[k] = 0; last_rd[k] = '0;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    mon_en = 1'b1;
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check_quiet(i, "reset");
      check_zero_regs(i, "reset");
    end

    // m0 read of 0x10 returns 0xDEADBEEF; m1 stays untouched.
    do_access(0, 0, 1'b0, 32'h10, 32'd0, 1, 0);
    chk("read_m0_rdata", m0_rdata[0], 32'hDEADBEEF);
    chk("read_m1_rdata", m1_rdata[0], 32'd0);
    chk("read_m1_done_cnt", 32'(done_cnt[1]), 32'd0);
    chk("read_m1_gnt_seen", 32'(m1_gnt_seen[0]), 32'd0);

    // m1 write of 0x12345678 to 0x20, then read it back.
    do_access(0, 1, 1'b1, 32'h20, 32'h12345678, 1, 0);
    chk("write_m1_rdata", m1_rdata[0], 32'd0);
    do_access(0, 1, 1'b0, 32'h20, 32'd0, 1, 0);
    chk("readback_m1_rdata", m1_rdata[0], 32'h12345678);

    // Round robin with both masters holding requests. The reset makes m0 win first.
    @(posedge clk); #1; rst[0] = 1'b1;
    @(posedge clk); #1; rst[0] = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    ev_m[0].delete(); ev_t[0].delete();
    expect_read(0, 0, 32'h30); expect_read(0, 0, 32'h30);
    expect_read(0, 1, 32'h40); expect_read(0, 1, 32'h40);
    set_req(0, 0, 1'b1, 1'b0, 32'h30, 32'd0);
    set_req(0, 1, 1'b1, 1'b0, 32'h40, 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk); #1;
      if (ev_m[0].size() >= 4) ok = 1'b1;
    end
    set_req(0, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(0, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rr_four_dones", 32'(ok), 32'd1);
    if (ok) begin
      for (int k = 0; k < 4; k++) chk("rr_order", 32'(ev_m[0][k]), 32'(k % 2));
      for (int k = 0; k < 3; k++) chk("rr_spacing", 32'(ev_t[0][k+1] - ev_t[0][k]), 32'd3);
    end
    repeat (5) @(negedge clk);
    #1;
    chk("rr_no_extra", 32'(ev_m[0].size()), 32'd4);
    chk("rr_m0_queue_empty", 32'(exp_q[0].size()), 32'd0);
    chk("rr_m1_queue_empty", 32'(exp_q[1].size()), 32'd0);

    // Fixed priority: m0 keeps winning until it drops its request.
    ev_m[1].delete(); ev_t[1].delete();
    m1_gnt_seen[1] = 1'b0;
    for (int k = 0; k < 3; k++) expect_read(1, 0, 32'h30);
    expect_read(1, 1, 32'h40);
    @(posedge clk); #1;
    set_req(1, 0, 1'b1, 1'b0, 32'h30, 32'd0);
    set_req(1, 1, 1'b1, 1'b0, 32'h40, 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk); #1;
      if (ev_m[1].size() >= 3) ok = 1'b1;
    end
    set_req(1, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("fp_three_dones", 32'(ok), 32'd1);
    chk("fp_m1_gnt_while_m0", 32'(m1_gnt_seen[1]), 32'd0);
    n = ev_m[1].size();
    for (int k = 0; k < n; k++) chk("fp_m0_wins", 32'(ev_m[1][k]), 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk); #1;
      if (ev_m[1].size() >= 4) ok = 1'b1;
    end
    set_req(1, 1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("fp_m1_served", 32'(ok), 32'd1);
    if (ok) begin
      chk("fp_m1_is_fourth", 32'(ev_m[1][3]), 32'd1);
      chk("fp_m1_within_one", 32'(ev_t[1][3] - ev_t[1][2]), 32'd3);
    end

    // RAM_LATENCY=3: a write holds ram_save for three cycles.
    do_access(2, 1, 1'b1, 32'h20, 32'h12345678, 3, 0);
    chk("l3_write_m1_rdata", m1_rdata[2], 32'd0);

    // Reset during the second ACCESS cycle aborts the access without a done pulse.
    n = done_cnt[4];
    @(posedge clk); #1;
    set_req(2, 0, 1'b1, 1'b0, 32'h50, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("abort_in_access_load", 32'(ram_load[2]), 32'd1);
    rst[2] = 1'b1;
    set_req(2, 0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    last_rd[4] = '0; last_rd[5] = '0;
    @(negedge clk); #1;
    check_quiet(2, "abort");
    check_zero_regs(2, "abort");
    repeat (6) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt[4] - n), 32'd0);

    // After the abort, an m1 read is served normally and returns the earlier write.
    do_access(2, 1, 1'b0, 32'h20, 32'd0, 3, 0);
    chk("l3_m1_readback", m1_rdata[2], 32'h12345678);

    // m0 withdraws its request after one ACCESS cycle; the access still completes.
    do_access(2, 0, 1'b0, 32'h70, 32'd0, 3, 1);
    chk("withdraw_m0_rdata", m0_rdata[2], 32'hC0FFEE70);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      check_quiet(2, "withdraw_idle");
    end

    for (int k = 0; k < 6; k++) chk("queue_drained", 32'(exp_q[k].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
